// File: rtl/npc_bpred_pkg.sv
// Shared NPCOp encodings, BTB entry kinds and direction-counter init values
// for the next-PC / branch prediction unit.
package npc_bpred_pkg;

    localparam logic [4:0] NPC_PLUS4  = 5'b00000;
    localparam logic [4:0] NPC_BRANCH = 5'b00001;
    localparam logic [4:0] NPC_JUMP   = 5'b00010;
    localparam logic [4:0] NPC_JALR   = 5'b00100;

    typedef enum logic {
        BP_KIND_COND   = 1'b0,
        BP_KIND_UNCOND = 1'b1
    } bp_kind_e;

    // Weakly-taken is MSB=1/rest 0; weakly-not-taken is MSB=0/rest 1.
    function automatic logic [3:0] ctr_init(input int unsigned bits, input logic taken);
        logic [3:0] msb;
        msb = 4'd1 << (bits - 1);
        return taken ? msb : (msb - 4'd1);
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// allocate/update with saturating direction counters from EX resolution.
module npc_btb
    import npc_bpred_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  bp_kind_e        upd_kind,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] WEAK_T   = CTR_BITS'(ctr_init(CTR_BITS, 1'b1));
    localparam logic [CTR_BITS-1:0] WEAK_NT  = CTR_BITS'(ctr_init(CTR_BITS, 1'b0));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic                valid_q  [DEPTH];
    logic [CTR_BITS-1:0] ctr_q    [DEPTH];
    logic [TAG_W-1:0]    tag_q    [DEPTH];
    logic [XLEN-1:0]     target_q [DEPTH];
    bp_kind_e            kind_q   [DEPTH];

    logic [IDX_W-1:0]    rd_idx, wr_idx;
    logic [TAG_W-1:0]    rd_tag, wr_tag;
    logic                rd_hit, wr_hit;
    logic [CTR_BITS-1:0] ctr_next;
    logic                unused_pc_bits;

    assign rd_idx = lookup_pc[IDX_W+1:2];
    assign rd_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[XLEN-1:IDX_W+2];
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken  = rd_hit && ((kind_q[rd_idx] == BP_KIND_UNCOND) || ctr_q[rd_idx][CTR_BITS-1]);
    assign pred_target = target_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        // NOTE: default assignment first so every path drives ctr_next and no latch is inferred.
        ctr_next = upd_taken ? WEAK_T : WEAK_NT;
        if (wr_hit) begin
            if (upd_taken)
                ctr_next = (ctr_q[wr_idx] == CTR_MAX) ? CTR_MAX : ctr_q[wr_idx] + CTR_BITS'(1);
            else
                ctr_next = (ctr_q[wr_idx] == '0) ? '0 : ctr_q[wr_idx] - CTR_BITS'(1);
        end
    end

    // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WEAK_NT;
            end
        end else if (upd_en) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= ctr_next;
        end
    end

    // NOTE: tag/target/kind are gated by valid, so they carry no reset and map onto plain storage.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= upd_target;
            kind_q[wr_idx]   <= upd_kind;
        end
    end

endmodule

// File: rtl/npc_bpred.sv
// Next-PC unit: IF PC register with BTB-based prediction, EX resolution,
// misprediction redirect and a wrapping misprediction counter.
module npc_bpred
    import npc_bpred_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 16,
    parameter int              CTR_BITS = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_npc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [4:0]      ex_npcop,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pred_npc,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispred_cnt
);

    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] actual_npc;
    logic            upd_en;
    bp_kind_e        upd_kind;

    assign upd_en   = ex_valid && (ex_npcop != NPC_PLUS4);
    assign upd_kind = ((ex_npcop == NPC_JUMP) || (ex_npcop == NPC_JALR)) ? BP_KIND_UNCOND
                                                                         : BP_KIND_COND;

    npc_btb #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .CTR_BITS (CTR_BITS)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc),
        .pred_taken  (pred_taken),
        .pred_target (btb_target),
        .upd_en      (upd_en),
        .upd_pc      (ex_pc),
        .upd_kind    (upd_kind),
        .upd_taken   (ex_taken),
        .upd_target  (ex_target)
    );

    assign pred_npc = pred_taken ? btb_target : pc + XLEN'(4);

    // A stale BTB hit on a PLUS4 instruction shows up here as a target mismatch.
    assign actual_npc  = ex_taken ? ex_target : ex_pc + XLEN'(4);
    assign mispredict  = ex_valid && (actual_npc != ex_pred_npc);
    assign redirect_pc = actual_npc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            mispred_cnt <= '0;
        end else begin
            if (mispredict)
                pc <= redirect_pc;
            else if (!stall)
                pc <= pred_npc;
            if (mispredict)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred: expectations are queued as stimulus is
// driven and popped against DUT outputs when they are sampled.
module tb_npc_bpred;
    import npc_bpred_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_npcop;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_npc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] mispred_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 32'd0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    npc_bpred #(
        .XLEN     (32),
        .DEPTH    (16),
        .CTR_BITS (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc          (pc),
        .pred_taken  (pred_taken),
        .pred_npc    (pred_npc),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_npcop    (ex_npcop),
        .ex_taken    (ex_taken),
        .ex_target   (ex_target),
        .ex_pred_npc (ex_pred_npc),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .mispred_cnt (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        checks++;
        if (val_q.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%h expected=<queued value>", obs);
        end else begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            assert (obs === v) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", t, obs, v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid    = 1'b0;
        ex_pc       = 32'h0;
        ex_npcop    = NPC_PLUS4;
        ex_taken    = 1'b0;
        ex_target   = 32'h0;
        ex_pred_npc = 32'h0;
    endtask

    task automatic set_ex(input logic [31:0] epc, input logic [4:0] op, input logic tk,
                          input logic [31:0] tgt, input logic [31:0] pnpc);
        ex_valid    = 1'b1;
        ex_pc       = epc;
        ex_npcop    = op;
        ex_taken    = tk;
        ex_target   = tgt;
        ex_pred_npc = pnpc;
    endtask

    // Force fetch to t with a PLUS4 instruction at t-4 whose carried prediction is wrong.
    task automatic redirect_to(input logic [31:0] t);
        set_ex(t - 32'd4, NPC_PLUS4, 1'b0, 32'h0, t ^ 32'h8000_0000);
        expect_val("redirect_pc", t);
        tick();
        observe(pc);
        exp_cnt++;
        idle();
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        idle();
        tick();

        // Reset state
        expect_val("rst_pc", 32'h0);
        expect_val("rst_pred_taken", 32'd0);
        expect_val("rst_pred_npc", 32'h4);
        expect_val("rst_cnt", 32'd0);
        expect_val("rst_mispredict", 32'd0);
        observe(pc);
        observe({31'd0, pred_taken});
        observe(pred_npc);
        observe(mispred_cnt);
        observe({31'd0, mispredict});
        rst = 1'b0;

        // Sequential fetch
        for (int i = 1; i <= 3; i++) begin
            expect_val("seq_pc", 32'(4 * i));
            tick();
            observe(pc);
        end
        expect_val("seq_pred_taken", 32'd0);
        observe({31'd0, pred_taken});

        // Branch 0x20 -> 0x40 taken on first encounter
        set_ex(32'h20, NPC_BRANCH, 1'b1, 32'h40, 32'h24);
        #1;
        expect_val("br_mispredict", 32'd1);
        expect_val("br_redirect", 32'h40);
        observe({31'd0, mispredict});
        observe(redirect_pc);
        expect_val("br_pc", 32'h40);
        tick();
        observe(pc);
        exp_cnt++;
        idle();
        expect_val("br_cnt", exp_cnt);
        #1;
        observe(mispred_cnt);

        redirect_to(32'h20);
        expect_val("br_hit_taken", 32'd1);
        expect_val("br_hit_npc", 32'h40);
        observe({31'd0, pred_taken});
        observe(pred_npc);

        // Not-taken twice: ctr 10 -> 01 -> 00
        set_ex(32'h20, NPC_BRANCH, 1'b0, 32'h40, 32'h40);
        #1;
        expect_val("nt1_mispredict", 32'd1);
        expect_val("nt1_redirect", 32'h24);
        observe({31'd0, mispredict});
        observe(redirect_pc);
        expect_val("nt1_pc", 32'h24);
        tick();
        observe(pc);
        exp_cnt++;
        set_ex(32'h20, NPC_BRANCH, 1'b0, 32'h40, 32'h24);
        #1;
        expect_val("nt2_mispredict", 32'd0);
        observe({31'd0, mispredict});
        tick();
        idle();
        redirect_to(32'h20);
        expect_val("nt_pred_taken", 32'd0);
        expect_val("nt_pred_npc", 32'h24);
        observe({31'd0, pred_taken});
        observe(pred_npc);

        // Further not-taken must saturate at 00
        set_ex(32'h20, NPC_BRANCH, 1'b0, 32'h40, 32'h24);
        tick();
        idle();
        redirect_to(32'h20);
        expect_val("sat_pred_taken", 32'd0);
        expect_val("sat_cnt", exp_cnt);
        observe({31'd0, pred_taken});
        observe(mispred_cnt);

        // Stall holds pc, mispredict overrides stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_val("stall_pc", 32'h20);
            tick();
            observe(pc);
        end
        set_ex(32'hFC, NPC_PLUS4, 1'b0, 32'h0, 32'h0);
        expect_val("stall_redirect_pc", 32'h100);
        tick();
        observe(pc);
        exp_cnt++;
        idle();
        stall = 1'b0;

        // Aliasing: JAL 0x08 and JAL 0x48 share index 2
        set_ex(32'h08, NPC_JUMP, 1'b1, 32'h80, 32'h0C);
        #1;
        expect_val("jal1_mispredict", 32'd1);
        observe({31'd0, mispredict});
        expect_val("jal1_pc", 32'h80);
        tick();
        observe(pc);
        exp_cnt++;
        set_ex(32'h48, NPC_JUMP, 1'b1, 32'h90, 32'h4C);
        tick();
        exp_cnt++;
        idle();
        redirect_to(32'h08);
        expect_val("alias_evict_taken", 32'd0);
        expect_val("alias_evict_npc", 32'h0C);
        observe({31'd0, pred_taken});
        observe(pred_npc);
        redirect_to(32'h48);
        expect_val("alias_hit_taken", 32'd1);
        expect_val("alias_hit_npc", 32'h90);
        observe({31'd0, pred_taken});
        observe(pred_npc);

        // PLUS4 at 0x48 after a stale hit
        set_ex(32'h48, NPC_PLUS4, 1'b0, 32'h0, 32'h90);
        #1;
        expect_val("stale_mispredict", 32'd1);
        expect_val("stale_redirect", 32'h4C);
        observe({31'd0, mispredict});
        observe(redirect_pc);
        expect_val("stale_pc", 32'h4C);
        tick();
        observe(pc);
        exp_cnt++;
        idle();
        redirect_to(32'h48);
        expect_val("stale_kept_npc", 32'h90);
        observe(pred_npc);

        // Same-cycle update and lookup on the same index sees the old entry
        set_ex(32'h48, NPC_JUMP, 1'b1, 32'hA0, 32'h90);
        #1;
        expect_val("same_cycle_npc", 32'h90);
        observe(pred_npc);
        expect_val("same_cycle_pc", 32'hA0);
        tick();
        observe(pc);
        exp_cnt++;
        idle();
        redirect_to(32'h48);
        expect_val("updated_npc", 32'hA0);
        observe(pred_npc);

        // PC wrap
        redirect_to(32'hFFFF_FFFC);
        expect_val("wrap_pred_taken", 32'd0);
        expect_val("wrap_pred_npc", 32'h0);
        observe({31'd0, pred_taken});
        observe(pred_npc);
        expect_val("wrap_pc", 32'h0);
        tick();
        observe(pc);

        // Asynchronous reset mid-stream
        redirect_to(32'h1234);
        expect_val("pre_rst_cnt", exp_cnt);
        observe(mispred_cnt);
        #2;
        rst = 1'b1;
        #1;
        expect_val("mid_rst_pc", 32'h0);
        expect_val("mid_rst_cnt", 32'd0);
        expect_val("mid_rst_pred_npc", 32'h4);
        observe(pc);
        observe(mispred_cnt);
        observe(pred_npc);
        tick();
        rst     = 1'b0;
        exp_cnt = 32'd0;
        redirect_to(32'h48);
        expect_val("post_rst_miss_48", 32'd0);
        observe({31'd0, pred_taken});
        redirect_to(32'h20);
        expect_val("post_rst_miss_20", 32'd0);
        expect_val("post_rst_cnt", exp_cnt);
        observe({31'd0, pred_taken});
        observe(mispred_cnt);

        checks++;
        assert (val_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", val_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npc_bpred.md
Name: npc_bpred

Overview:
Parametrised next-PC unit for the pipelined RV32I core. It holds the IF-stage PC register and predicts the next fetch address from a direct-mapped branch target buffer (BTB) with saturating direction counters. It accepts resolution and update information from EX, detects mispredictions, redirects fetch, and counts mispredictions. It replaces the purely combinational next-PC selection.

Parameters:
XLEN, 32, address/data width
DEPTH, 16, BTB entries; power of two, 2..256; IDX_W = log2(DEPTH)
CTR_BITS, 2, direction counter width (2..4)
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold PC
pc  out  XLEN  current IF PC (registered)
pred_taken  out  1  prediction for the instruction at pc; carried down the pipeline
pred_npc  out  XLEN  predicted next PC for pc; carried down the pipeline
ex_valid  in  1  instruction in EX is valid (not a bubble)
ex_pc  in  XLEN  PC of the EX instruction
ex_npcop  in  5  NPCOp of the EX instruction (shared NPC_* encoding)
ex_taken  in  1  actual outcome; must be 1 for NPC_JUMP and NPC_JALR
ex_target  in  XLEN  actual target (PC+IMM, or ALU result for JALR)
ex_pred_npc  in  XLEN  pred_npc that travelled with the EX instruction
mispredict  out  1  flush IF/ID and ID/EX this cycle
redirect_pc  out  XLEN  correct next PC when mispredict=1
mispred_cnt  out  32  wrapping count of mispredictions

Behaviour:
- Index: idx = pc[IDX_W+1:2]. Tag: pc[XLEN-1:IDX_W+2]. Each entry holds valid, tag, target, kind (cond/uncond), and ctr.
- Lookup is combinational on pc, using table contents from before the current edge.
  - hit = valid && tag match.
  - pred_taken = hit && (kind == uncond || ctr MSB == 1).
  - pred_npc = pred_taken ? target : pc + 4. pc + 4 wraps modulo 2^XLEN.
- Resolution (combinational):
  - actual = ex_taken ? ex_target : ex_pc + 4.
  - mispredict = ex_valid && (actual != ex_pred_npc).
  - redirect_pc = actual.
  - NPC_PLUS4 instructions also mispredict on a stale BTB hit (aliasing). The entry is not modified in that case.
- Next PC priority at each edge:
  - rst.
  - mispredict: pc <= redirect_pc. Applies even when stall=1.
  - stall: pc holds.
  - otherwise pc <= pred_npc.
- Update fires at the edge when ex_valid && ex_npcop != NPC_PLUS4. It is independent of stall.
  - Tag match (hit): target <= ex_target, kind updated. ctr increments if taken, decrements if not, saturating at 0 and 2^CTR_BITS-1.
  - Miss: allocate the entry (replacing any occupant). valid=1, tag, target, kind (uncond for NPC_JUMP/NPC_JALR). ctr = taken ? weakly-taken (MSB=1, others 0) : weakly-not-taken (MSB=0, others 1).
- Same-cycle update and lookup on the same index: lookup sees the old entry. The update is visible from the next cycle.
- mispred_cnt increments by 1 at each edge where mispredict=1 and wraps at 2^32.
- Reset (asynchronous, also mid-operation) sets:
  - pc = RESET_PC.
  - all valid = 0, all ctr = weakly-not-taken; target/tag contents are don't-care.
  - mispred_cnt = 0.
  - Outputs after reset: pred_taken=0, pred_npc=RESET_PC+4, mispredict follows inputs.
- Misaligned ex_target is stored and redirected as-is. Alignment faults are out of scope.

Decomposition:
- ctrl_encode_def.v (shared): existing NPC_PLUS4/NPC_BRANCH/NPC_JUMP/NPC_JALR codes. Add BP_KIND_COND/BP_KIND_UNCOND and the weak-counter init values as macros.
- One sub-module, npc_btb: the tables, combinational lookup, and update/saturation logic.
- npc_bpred keeps the PC register, priority mux, resolution compare and counter.

Test Plan:
- Reset then no control flow, stall=0 -> pc sequence 0, 4, 8, 12; pred_taken=0; mispred_cnt=0.
- Branch at 0x20, target 0x40, resolved taken on first encounter -> mispredict=1, redirect_pc=0x40, pc=0x40 next cycle, mispred_cnt=1. Next fetch of 0x20 -> pred_taken=1, pred_npc=0x40, no mispredict.
- Same branch resolved not-taken 2x after allocation (ctr 10->01->00) -> first not-taken mispredicts. Third fetch predicts pc+4 = 0x24. Counter stays at 00 after a further not-taken.
- stall=1 for 3 cycles with no mispredict -> pc holds. stall=1 with mispredict=1 and redirect 0x100 -> pc=0x100 next edge.
- DEPTH=16: JAL at 0x08 (target 0x80) then JAL at 0x48 (same idx 2) -> second replaces first. Fetch 0x08 -> pred_taken=0. PLUS4 instruction at 0x48 after a stale hit -> mispredict, redirect 0x4C.
- Assert rst mid-stream with pc=0x1234 -> pc=RESET_PC immediately, all lookups miss, mispred_cnt=0. pc=0xFFFF_FFFC with no hit -> pred_npc=0x0.
